// File: rtl/smul_simd.sv
// ============================================================================
// smul_simd - packed signed SIMD multiply-accumulate, 8/16/32/64-bit lanes.
// Optional macro SMUL_SAT_EN selects lane saturation instead of wrap.
// Revision: 1.0
// ============================================================================
`default_nettype none

module smul_simd #(
    parameter int DATA_W = 64,
    parameter int PIPE   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sclr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] input_data,
    input  logic [DATA_W-1:0] weight,
    input  logic [3:0]        select_precision,
    input  logic              acc_en,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] res_mac_next,
    output logic              prec_err
);

    localparam int NS = (PIPE > 1) ? PIPE - 1 : 1;
`ifdef SMUL_SAT_EN
    localparam int PF = 2;
`else
    localparam int PF = 1;
`endif
    localparam int PW = DATA_W * PF;

    logic              out_valid_q;
    logic [DATA_W-1:0] res_q;
    logic              prec_err_q;
    logic [DATA_W-1:0] acc_q;

    logic [1:0] w_in_idx;
    logic       w_in_ill;

    always_comb begin
        w_in_idx = 2'd0;
        w_in_ill = 1'b0;
        case (select_precision)
            4'b0001: w_in_idx = 2'd0;
            4'b0010: w_in_idx = 2'd1;
            4'b0100: w_in_idx = 2'd2;
            4'b1000: begin
                w_in_idx = 2'd3;
                w_in_ill = (DATA_W < 64);
            end
            default: w_in_ill = 1'b1;
        endcase
    end

    // Lane products for every width; only the reduced width is kept when wrapping.
    wire [PW-1:0] w_prod [4];

    generate
        for (genvar p = 0; p < 4; p++) begin : g_prod
            localparam int LW  = 8 << p;
            localparam int LWP = LW * PF;
            for (genvar k = 0; k < DATA_W / LW; k++) begin : g_lane
                logic signed [LWP-1:0] w_x;
                logic signed [LWP-1:0] w_y;
                assign w_x = LWP'($signed(input_data[k*LW +: LW]));
                assign w_y = LWP'($signed(weight[k*LW +: LW]));
                assign w_prod[p][k*LWP +: LWP] = w_x * w_y;
            end
        end
    endgenerate

    logic          w_en_out;
    logic [PW-1:0] w_fin_prod;
    logic [1:0]    w_fin_idx;
    logic          w_fin_ill;
    logic          w_fin_ae;
    logic          w_fin_v;

    assign w_en_out = !out_valid_q || out_ready;

    generate
        if (PIPE > 1) begin : g_pipe
            logic [PW-1:0] prod_q [NS];
            logic [1:0]    idx_q  [NS];
            logic [NS-1:0] ill_q;
            logic [NS-1:0] ae_q;
            logic [NS-1:0] v_q;
            logic [NS-1:0] w_en;

            // A stage may load unless it and everything downstream is full and stalled.
            always_comb begin
                for (int i = 0; i < NS; i++) begin
                    w_en[i] = !(out_valid_q &&
                                ((v_q | NS'((64'd1 << i) - 64'd1)) == {NS{1'b1}}))
                              || out_ready;
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    v_q   <= '0;
                    ill_q <= '0;
                    ae_q  <= '0;
                    for (int i = 0; i < NS; i++) begin
                        prod_q[i] <= '0;
                        idx_q[i]  <= 2'd0;
                    end
                end else if (sclr) begin
                    v_q <= '0;
                end else begin
                    if (w_en[0]) begin
                        v_q[0]    <= in_valid;
                        prod_q[0] <= w_prod[w_in_idx];
                        idx_q[0]  <= w_in_idx;
                        ill_q[0]  <= w_in_ill;
                        ae_q[0]   <= acc_en;
                    end
                    for (int i = 1; i < NS; i++) begin
                        if (w_en[i]) begin
                            v_q[i]    <= v_q[i-1];
                            prod_q[i] <= prod_q[i-1];
                            idx_q[i]  <= idx_q[i-1];
                            ill_q[i]  <= ill_q[i-1];
                            ae_q[i]   <= ae_q[i-1];
                        end
                    end
                end
            end

            assign in_ready   = w_en[0];
            assign w_fin_v    = v_q[NS-1];
            assign w_fin_prod = prod_q[NS-1];
            assign w_fin_idx  = idx_q[NS-1];
            assign w_fin_ill  = ill_q[NS-1];
            assign w_fin_ae   = ae_q[NS-1];
        end else begin : g_direct
            assign in_ready   = w_en_out;
            assign w_fin_v    = in_valid;
            assign w_fin_prod = w_prod[w_in_idx];
            assign w_fin_idx  = w_in_idx;
            assign w_fin_ill  = w_in_ill;
            assign w_fin_ae   = acc_en;
        end
    endgenerate

    // Accumulation happens at output write so each beat sees the freshest acc.
    wire [DATA_W-1:0] w_res [4];

    generate
        for (genvar p = 0; p < 4; p++) begin : g_red
            localparam int LW  = 8 << p;
            localparam int LWP = LW * PF;
            for (genvar k = 0; k < DATA_W / LW; k++) begin : g_lane
                logic [LW-1:0]  w_a;
                logic [LWP-1:0] w_pr;
                assign w_a  = acc_q[k*LW +: LW];
                assign w_pr = w_fin_prod[k*LWP +: LWP];
`ifdef SMUL_SAT_EN
                logic [2*LW:0] w_sum;
                logic          w_fits;
                assign w_sum  = (2*LW+1)'($signed(w_pr))
                              + (w_fin_ae ? (2*LW+1)'($signed(w_a)) : '0);
                assign w_fits = (w_sum[2*LW:LW-1] == '0) || (w_sum[2*LW:LW-1] == '1);
                assign w_res[p][k*LW +: LW] = w_fits ? w_sum[LW-1:0] :
                                              (w_sum[2*LW] ? {1'b1, {(LW-1){1'b0}}}
                                                           : {1'b0, {(LW-1){1'b1}}});
`else
                assign w_res[p][k*LW +: LW] = w_pr + (w_fin_ae ? w_a : '0);
`endif
            end
        end
    endgenerate

    logic [DATA_W-1:0] res_d;
    assign res_d = w_res[w_fin_idx];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            res_q       <= '0;
            prec_err_q  <= 1'b0;
            acc_q       <= '0;
        end else if (sclr) begin
            out_valid_q <= 1'b0;
            res_q       <= '0;
            prec_err_q  <= 1'b0;
            acc_q       <= '0;
        end else if (w_en_out) begin
            out_valid_q <= w_fin_v;
            if (w_fin_v) begin
                if (w_fin_ill) begin
                    res_q      <= '0;
                    prec_err_q <= 1'b1;
                end else begin
                    res_q      <= res_d;
                    prec_err_q <= 1'b0;
                    acc_q      <= res_d;
                end
            end
        end
    end

    assign out_valid    = out_valid_q;
    assign res_mac_next = res_q;
    assign prec_err     = prec_err_q;

endmodule

`default_nettype wire

// File: tb/tb_smul_simd.sv
// ============================================================================
// tb_smul_simd - self-checking bench for smul_simd with a scoreboard queue.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_smul_simd;

    localparam int DATA_W = 64;
    localparam int PIPE   = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              sclr;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] input_data;
    logic [DATA_W-1:0] weight;
    logic [3:0]        select_precision;
    logic              acc_en;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] res_mac_next;
    logic              prec_err;

    smul_simd #(.DATA_W(DATA_W), .PIPE(PIPE)) dut (
        .clk              (clk),
        .rst              (rst),
        .sclr             (sclr),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .input_data       (input_data),
        .weight           (weight),
        .select_precision (select_precision),
        .acc_en           (acc_en),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .res_mac_next     (res_mac_next),
        .prec_err         (prec_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0] res;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    logic [63:0] m_acc;
    logic [63:0] mon_last;
    int          mon_count;
    int          checks;
    int          errors;

`ifdef SMUL_SAT_EN
    localparam logic [63:0] EXP16 = 64'h7FFF;
`else
    localparam logic [63:0] EXP16 = 64'h0000;
`endif

    // Reference: exact wide arithmetic per lane, then reduce.
    function automatic exp_t model_beat(input logic [63:0] d, input logic [63:0] w,
                                        input logic [3:0] prec, input logic ae);
        exp_t               e;
        int                 lw;
        logic [63:0]        mask, dl, wl, al;
        logic signed [129:0] xs, ws, as_, s, hi, lo;
        e.res = '0;
        e.err = 1'b0;
        case (prec)
            4'b0001: lw = 8;
            4'b0010: lw = 16;
            4'b0100: lw = 32;
            4'b1000: lw = 64;
            default: lw = 0;
        endcase
        if (lw == 0) begin
            e.err = 1'b1;
            return e;
        end
        mask = (lw == 64) ? '1 : ((64'd1 << lw) - 64'd1);
        hi   = (130'sd1 <<< (lw - 1)) - 130'sd1;
        lo   = -(130'sd1 <<< (lw - 1));
        for (int k = 0; k < 64 / lw; k++) begin
            dl  = (d >> (k * lw)) & mask;
            wl  = (w >> (k * lw)) & mask;
            al  = (m_acc >> (k * lw)) & mask;
            xs  = $signed({66'd0, dl});
            ws  = $signed({66'd0, wl});
            as_ = $signed({66'd0, al});
            if (dl[lw-1]) xs  = xs  - (130'sd1 <<< lw);
            if (wl[lw-1]) ws  = ws  - (130'sd1 <<< lw);
            if (al[lw-1]) as_ = as_ - (130'sd1 <<< lw);
            s = xs * ws + (ae ? as_ : 130'sd0);
`ifdef SMUL_SAT_EN
            if (s > hi) s = hi;
            else if (s < lo) s = lo;
`endif
            e.res = e.res | ((s[63:0] & mask) << (k * lw));
        end
        m_acc = e.res;
        return e;
    endfunction

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            checks++;
            mon_count++;
            mon_last = res_mac_next;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output got res=%h err=%b, none expected",
                         res_mac_next, prec_err);
            end else begin
                mon_e = sb.pop_front();
                if (res_mac_next !== mon_e.res || prec_err !== mon_e.err) begin
                    errors++;
                    $display("FAIL scoreboard got res=%h err=%b expected res=%h err=%b",
                             res_mac_next, prec_err, mon_e.res, mon_e.err);
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [63:0] d, input logic [63:0] w,
                        input logic [3:0] prec, input logic ae);
        bit acc;
        int n;
        acc = 1'b0;
        n   = 0;
        in_valid = 1'b1;
        input_data = d;
        weight = w;
        select_precision = prec;
        acc_en = ae;
        while (!acc && n < 100) begin
            @(negedge clk);
            if (in_ready) begin
                acc = 1'b1;
                sb.push_back(model_beat(d, w, prec, ae));
            end
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL send_timeout in_ready stuck low, expected acceptance");
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d required=0", sb.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks += 3;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b req=0", out_valid); end
        if (prec_err !== 1'b0) begin errors++; $display("FAIL reset_prec_err got=%b req=0", prec_err); end
        if (res_mac_next !== 64'd0) begin errors++; $display("FAIL reset_res got=%h req=0", res_mac_next); end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b req=1", in_ready); end
    endtask

    task automatic test_int8_latency();
        int n;
        send(64'h07, 64'hFD, 4'b0001, 1'b0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 20);
        checks += 2;
        if (n != PIPE) begin errors++; $display("FAIL int8_latency got=%0d req=%0d", n, PIPE); end
        if (res_mac_next !== 64'hEB) begin errors++; $display("FAIL int8_value got=%h req=00000000000000eb", res_mac_next); end
        @(posedge clk);
        #1;
        wait_drain();
    endtask

    task automatic test_int16();
        send(64'h0100, 64'h0100, 4'b0010, 1'b0);
        wait_drain();
        checks++;
        if (mon_last !== EXP16) begin errors++; $display("FAIL int16_overflow got=%h req=%h", mon_last, EXP16); end
    endtask

    task automatic test_accum();
        int c0;
        c0 = mon_count;
        send(64'd5, 64'd6, 4'b0100, 1'b0);
        send(64'd5, 64'd6, 4'b0100, 1'b1);
        send(64'd5, 64'd6, 4'b0100, 1'b1);
        wait_drain();
        checks += 2;
        if (mon_count - c0 != 3) begin errors++; $display("FAIL accum_count got=%0d req=3", mon_count - c0); end
        if (mon_last !== 64'd90) begin errors++; $display("FAIL accum_final got=%0d req=90", mon_last); end
    endtask

    task automatic test_backpressure();
        int          c0;
        logic        cv, ce, saw;
        logic [63:0] cr;
        c0 = mon_count;
        fork
            begin
                for (int i = 0; i < 8; i++)
                    send({$urandom, $urandom}, {$urandom, $urandom}, 4'b0010, 1'($urandom_range(0, 1)));
            end
            begin
                repeat (3) @(posedge clk);
                #1;
                out_ready = 1'b0;
                @(negedge clk);
                cv = out_valid; cr = res_mac_next; ce = prec_err;
                saw = !in_ready;
                repeat (4) begin
                    @(negedge clk);
                    checks++;
                    if (out_valid !== cv || res_mac_next !== cr || prec_err !== ce) begin
                        errors++;
                        $display("FAIL stall_hold got v=%b r=%h e=%b req v=%b r=%h e=%b",
                                 out_valid, res_mac_next, prec_err, cv, cr, ce);
                    end
                    if (!in_ready) saw = 1'b1;
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
                checks += 2;
                if (cv !== 1'b1) begin errors++; $display("FAIL stall_valid got=%b req=1", cv); end
                if (saw !== 1'b1) begin errors++; $display("FAIL stall_in_ready got=never_low req=low"); end
            end
        join
        wait_drain();
        checks++;
        if (mon_count - c0 != 8) begin errors++; $display("FAIL stall_count got=%0d req=8", mon_count - c0); end
    endtask

    task automatic test_illegal();
        send(64'd3, 64'd4, 4'b0100, 1'b0);
        send({$urandom, $urandom}, {$urandom, $urandom}, 4'b0011, 1'b1);
        send(64'd2, 64'd5, 4'b0100, 1'b1);
        wait_drain();
        checks++;
        if (mon_last !== 64'd22) begin errors++; $display("FAIL illegal_then_acc got=%0d req=22", mon_last); end
    endtask

    task automatic test_rst_mid();
        int cnt;
        in_valid = 1'b1; select_precision = 4'b0001; acc_en = 1'b0;
        input_data = 64'd1; weight = 64'd1;
        @(posedge clk); #1;
        input_data = 64'd2; weight = 64'd2;
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        checks += 2;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid got=%b req=0", out_valid); end
        if (res_mac_next !== 64'd0) begin errors++; $display("FAIL rst_mid_res got=%h req=0", res_mac_next); end
        @(negedge clk);
        rst = 1'b0;
        m_acc = '0;
        sb.delete();
        cnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) cnt++;
        end
        checks++;
        if (cnt != 0) begin errors++; $display("FAIL rst_mid_emit got=%0d req=0", cnt); end
        @(posedge clk); #1;
    endtask

    task automatic test_sclr();
        int cnt;
        send(64'd5, 64'd6, 4'b0100, 1'b0);
        wait_drain();
        in_valid = 1'b1; select_precision = 4'b0100; acc_en = 1'b1;
        input_data = 64'd7; weight = 64'd7;
        sclr = 1'b1;
        @(posedge clk); #1;
        sclr = 1'b0;
        in_valid = 1'b0;
        m_acc = '0;
        cnt = 0;
        repeat (4) begin
            @(negedge clk);
            if (out_valid) cnt++;
        end
        checks++;
        if (cnt != 0) begin errors++; $display("FAIL sclr_drop got=%0d req=0", cnt); end
        @(posedge clk); #1;
        send(64'd2, 64'd3, 4'b0100, 1'b1);
        wait_drain();
        checks++;
        if (mon_last !== 64'd6) begin errors++; $display("FAIL sclr_acc got=%0d req=6", mon_last); end
    endtask

    task automatic test_random();
        bit          done;
        int          r;
        logic [3:0]  prec;
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    r = $urandom_range(0, 8);
                    prec = (r < 4) ? 4'(1 << r) : ((r < 8) ? 4'(1 << (r - 4)) : 4'b0110);
                    send({$urandom, $urandom}, {$urandom, $urandom}, prec, 1'($urandom_range(0, 1)));
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk); #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        wait_drain();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

    initial begin
        checks = 0; errors = 0; mon_count = 0;
        m_acc = '0; mon_last = '0;
        rst = 1'b1; sclr = 1'b0; in_valid = 1'b0; acc_en = 1'b0;
        input_data = '0; weight = '0; select_precision = 4'b0001; out_ready = 1'b1;
        test_reset();
        test_int8_latency();
        test_int16();
        test_accum();
        test_backpressure();
        test_illegal();
        test_rst_mid();
        test_sclr();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
